// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-stage state and next-PC selection.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its hold / +4 / redirect next-PC select.
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h00000000
) (
  input  logic    CLK,
  input  logic    nRST,
  input  pc_sel_t pc_sel,
  input  word_t   redirect_addr,
  output word_t   pc,
  output word_t   pcp4
);

  word_t pc_next;

  assign pcp4 = pc + WORD_W'(4);

  // Redirect targets are forced word-aligned.
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_INC:      pc_next = pcp4;
      PC_REDIRECT: pc_next = redirect_addr & ~WORD_W'(3);
      default:     pc_next = pc;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams words into IF/ID, buffers one word across
// a decode stall, and handles redirects and halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic [31:0] instr_out,
  output logic [31:0] pcp4_out
);

  fetch_state_t state, next_state;
  pc_sel_t      pc_sel;
  word_t        pc, pcp4;
  word_t        ibuf;
  logic         ibuf_load;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .CLK           (CLK),
    .nRST          (nRST),
    .pc_sel        (pc_sel),
    .redirect_addr (redirect_addr),
    .pc            (pc),
    .pcp4          (pcp4)
  );

  assign imemaddr = pc;
  assign pcp4_out = pcp4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      ibuf  <= '0;
    end else begin
      state <= next_state;
      if (ibuf_load) begin
        ibuf <= imemload;
      end
    end
  end

  // Priority within an active state: halt, then redirect, then stall/ihit.
  always_comb begin
    next_state  = state;
    pc_sel      = PC_HOLD;
    ibuf_load   = 1'b0;
    imemREN     = 1'b0;
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    instr_out   = imemload;

    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (halt) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          next_state  = HALTED;
        end else if (redirect) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          pc_sel      = PC_REDIRECT;
        end else if (ihit && !stall) begin
          ifid_enable = 1'b1;
          pc_sel      = PC_INC;
        end else if (ihit) begin
          ibuf_load  = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        instr_out = ibuf;
        if (halt) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          next_state  = HALTED;
        end else if (redirect) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          pc_sel      = PC_REDIRECT;
          next_state  = FETCH;
        end else if (!stall) begin
          ifid_enable = 1'b1;
          pc_sel      = PC_INC;
          next_state  = FETCH;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    // Outputs stay quiet for the whole time reset is held.
    if (!nRST) begin
      imemREN     = 1'b0;
      ifid_enable = 1'b0;
      ifid_flush  = 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  clock, rising-edge.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ihit  input  1  instruction memory returns valid data this cycle.
REQ-005 SHALL have port: imemload  input  32  instruction word from memory, valid when ihit=1.
REQ-006 SHALL have port: stall  input  1  hazard unit holds the decode stage.
REQ-007 SHALL have port: redirect  input  1  taken branch/jump resolved downstream.
REQ-008 SHALL have port: redirect_addr  input  32  redirect target.
REQ-009 SHALL have port: halt  input  1  committed halt from a later stage.
REQ-010 SHALL have port: imemREN  output  1  instruction read request.
REQ-011 SHALL have port: imemaddr  output  32  instruction address, equal to PC.
REQ-012 SHALL have port: ifid_enable  output  1  IF/ID latch load enable.
REQ-013 SHALL have port: ifid_flush  output  1  IF/ID latch clears to zero on load.
REQ-014 SHALL have port: instr_out  output  32  instruction word presented to IF/ID.
REQ-015 SHALL have port: pcp4_out  output  32  PC+4 of instr_out.

Function
REQ-016 SHALL implement three states: FETCH, HOLD, HALTED.
REQ-017 SHALL hold a 32-bit PC register and a 32-bit ibuf register; all outputs are combinational from state, PC, ibuf and inputs.
REQ-018 SHALL compute pcp4 = PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-019 SHALL, in FETCH: assert imemREN=1, imemaddr=PC, pcp4_out=PC+4.
REQ-020 SHALL, in FETCH with ihit=1 and stall=0: present ifid_enable=1, instr_out=imemload, and set PC<=PC+4 at the next edge (zero added latency).
REQ-021 SHALL, in FETCH with ihit=1 and stall=1: keep ifid_enable=0, capture ibuf<=imemload, and move to HOLD.
REQ-022 SHALL, in FETCH with ihit=0: keep ifid_enable=0 and leave PC unchanged.
REQ-023 SHALL, in HOLD: drive imemREN=0 and instr_out=ibuf; when stall=0, assert ifid_enable=1, set PC<=PC+4 and return to FETCH; when stall=1, remain in HOLD.
REQ-024 SHALL, on redirect=1 in FETCH or HOLD: assert ifid_enable=1 and ifid_flush=1, set PC<=redirect_addr with bits [1:0] forced to 00, discard ibuf and any ihit data, and go to FETCH; this overrides stall and ihit.
REQ-025 SHALL, on halt=1 in any state: go to HALTED at the next edge; halt overrides redirect, stall and ihit, and the same cycle drives ifid_enable=1, ifid_flush=1.
REQ-026 SHALL, in HALTED: drive imemREN=0, ifid_enable=0, ifid_flush=0 and hold PC; only reset exits HALTED.
REQ-027 SHALL drive ifid_flush=0 whenever ifid_enable=0.
REQ-028 SHALL drive instr_out=imemload in FETCH and ibuf in HOLD; the value is don't-care when ifid_enable=0.

Reset
REQ-029 SHALL, while nRST=0: set PC=RESET_PC, ibuf=0, state=FETCH, and force imemREN=0, ifid_enable=0, ifid_flush=0.
REQ-030 SHALL abandon any in-flight fetch, HOLD or HALTED condition when reset asserts mid-operation; the first request after release is at RESET_PC.

Structure
REQ-031 SHALL take word_t and fetch_state_t (FETCH, HOLD, HALTED) from cpu_types_pkg.
REQ-032 SHALL place the PC register, including its next-PC select (hold, +4, redirect), in one sub-module, pc_reg.

Verification
REQ-033 SHALL cover streaming: reset, then ihit=1 for 3 cycles with imemload=A,B,C -> imemaddr 0,4,8; pcp4_out 4,8,12; ifid_enable=1 each cycle.
REQ-034 SHALL cover stall buffering: ihit=1, imemload=32'h8C220004, stall=1 for 2 cycles -> HOLD, imemREN=0; on stall=0: instr_out=32'h8C220004, ifid_enable=1, next imemaddr=4.
REQ-035 SHALL cover redirect over stall: in HOLD, redirect=1, redirect_addr=32'h00000103 -> ifid_flush=1, next imemaddr=32'h00000100, state FETCH.
REQ-036 SHALL cover halt over redirect: halt=1 and redirect=1 together -> HALTED; imemREN stays 0 and PC frozen for 10 cycles.
REQ-037 SHALL cover wrap-around: redirect to 32'hFFFFFFFC, then ihit=1 -> pcp4_out=0, next imemaddr=0.
REQ-038 SHALL cover reset mid-HOLD: nRST low for 1 cycle -> outputs zero immediately; after release, imemaddr=RESET_PC and imemREN=1.
